// File: rtl/mem_boot_loader_if.sv
// ----------------------------------------------------------------------------
// mem_boot_loader_if : byte-stream handshake and mem write bus of the loader
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_boot_loader_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic [7:0] o_waddr;
  logic [7:0] o_wdata;
  logic       o_we;
  logic       o_cpu_rstn;
  logic       o_done;
  logic       o_err;

  // Loader side
  modport slave (
    input  i_valid, i_data,
    output o_ready, o_waddr, o_wdata, o_we, o_cpu_rstn, o_done, o_err
  );

  // Byte source / system side
  modport master (
    output i_valid, i_data,
    input  o_ready, o_waddr, o_wdata, o_we, o_cpu_rstn, o_done, o_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_boot_loader.sv
// ----------------------------------------------------------------------------
// mem_boot_loader : loads a framed byte stream into mem, then releases the CPU
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_boot_loader (
  input  logic             i_clk,
  input  logic             i_rstn,
  mem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_SUM  = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] count, count_nxt;
  logic [7:0] addr, addr_nxt;
  logic [7:0] sum, sum_nxt;
  logic [7:0] waddr, waddr_nxt;
  logic [7:0] wdata, wdata_nxt;
  logic       we, we_nxt;
  logic       cpu_rstn, cpu_rstn_nxt;
  logic       done, done_nxt;
  logic       err, err_nxt;
  logic       ready;
  logic       accept;

  // Ready is gated by reset so nothing is acknowledged while the loader is held
  assign ready  = i_rstn && ((state == S_LEN) || (state == S_DATA) || (state == S_SUM));
  assign accept = bus.i_valid && ready;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state    <= S_LEN;
      count    <= 9'd0;
      addr     <= 8'h00;
      sum      <= 8'h00;
      waddr    <= 8'h00;
      wdata    <= 8'h00;
      we       <= 1'b0;
      cpu_rstn <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      addr     <= addr_nxt;
      sum      <= sum_nxt;
      waddr    <= waddr_nxt;
      wdata    <= wdata_nxt;
      we       <= we_nxt;
      cpu_rstn <= cpu_rstn_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    addr_nxt     = addr;
    sum_nxt      = sum;
    waddr_nxt    = waddr;
    wdata_nxt    = wdata;
    we_nxt       = 1'b0;
    cpu_rstn_nxt = cpu_rstn;
    done_nxt     = done;
    err_nxt      = err;

    case (state)
      S_LEN: begin
        if (accept) begin
          // A zero length byte encodes a full 256-byte payload
          count_nxt = (bus.i_data == 8'h00) ? 9'd256 : {1'b0, bus.i_data};
          addr_nxt  = 8'h00;
          sum_nxt   = 8'h00;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          waddr_nxt = addr;
          wdata_nxt = bus.i_data;
          we_nxt    = 1'b1;
          addr_nxt  = addr + 8'd1;
          sum_nxt   = sum + bus.i_data;
          count_nxt = count - 9'd1;
          if (count == 9'd1) begin
            state_nxt = S_SUM;
          end
        end
      end
      S_SUM: begin
        if (accept) begin
          if (bus.i_data == sum) begin
            state_nxt    = S_RUN;
            done_nxt     = 1'b1;
            cpu_rstn_nxt = 1'b1;
          end else begin
            state_nxt = S_ERR;
            err_nxt   = 1'b1;
          end
        end
      end
      S_RUN: begin
        cpu_rstn_nxt = 1'b1;
      end
      S_ERR: begin
        cpu_rstn_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_LEN;
      end
    endcase
  end

  assign bus.o_ready    = ready;
  assign bus.o_waddr    = waddr;
  assign bus.o_wdata    = wdata;
  assign bus.o_we       = we;
  assign bus.o_cpu_rstn = cpu_rstn;
  assign bus.o_done     = done;
  assign bus.o_err      = err;

endmodule

`default_nettype wire
